hex_scan: RTL and testbench



---
 rtl/hex_scan_if.sv | 21 ++
 rtl/hex_scan.sv | 209 ++++++++++++++++++++
 tb/tb_hex_scan.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hex_scan_if.sv
// Register-port bundle for hex_scan: classic cyc/stb handshake with a single-cycle acknowledge.
interface hex_scan_if;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic        adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/hex_scan.sv
// hex_scan: 8-digit time-multiplexed seven-segment scan controller with a VALUE/CTRL register port.
// Define HEX_SCAN_BLINK_EN to build in the per-digit blink mask (CTRL[23:16]) and its phase counter.
module hex_scan #(
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLINK_DIV = 8388608
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  hex_scan_if.slave  bus,
  output logic [3:0] nibble_o,
  output logic [7:0] dig_n_o
);

  localparam int unsigned     CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

  // Byte-lane merge of a bus write into an existing register image.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]   value_r;
  logic [7:0]    mask_r;
  logic          blank_r;
  logic          ack_r;
  logic [31:0]   dat_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [3:0]    nibble_r;
  logic [7:0]    dig_n_r;

  logic          xfer_s;
  logic          wr_s;
  logic [7:0]    blink_rd_s;
  logic          hide_s;
  logic [31:0]   ctrl_rd_s;
  logic [31:0]   ctrl_wr_s;
  logic [31:0]   rdata_s;
  logic [31:0]   value_nxt_s;
  logic [7:0]    mask_nxt_s;
  logic          blank_nxt_s;
  logic          ack_nxt_s;
  logic [31:0]   dat_nxt_s;
  logic [CW-1:0] cnt_nxt_s;
  logic [2:0]    idx_nxt_s;
  logic          dig_on_s;
  logic [3:0]    nibble_nxt_s;
  logic [7:0]    dig_n_nxt_s;

  assign ctrl_rd_s = {8'h00, blink_rd_s, 7'h00, blank_r, mask_r};
  assign ctrl_wr_s = lane_merge(ctrl_rd_s, bus.dat_i, bus.sel_i);

  // Bus decode: accept one transfer per ack-free cycle, merge writes, select read data.
  always_comb begin
    xfer_s      = bus.cyc_i & bus.stb_i & ~ack_r;
    wr_s        = xfer_s & bus.we_i;
    ack_nxt_s   = xfer_s;
    value_nxt_s = value_r;
    mask_nxt_s  = mask_r;
    blank_nxt_s = blank_r;
    if (bus.adr_i) begin
      rdata_s = ctrl_rd_s;
    end else begin
      rdata_s = value_r;
    end
    if (wr_s && !bus.adr_i) begin
      value_nxt_s = lane_merge(value_r, bus.dat_i, bus.sel_i);
    end else if (wr_s && bus.adr_i) begin
      mask_nxt_s  = ctrl_wr_s[7:0];
      blank_nxt_s = ctrl_wr_s[8];
    end else begin
      value_nxt_s = value_r;
    end
    if (xfer_s && !bus.we_i) begin
      dat_nxt_s = rdata_s;
    end else begin
      dat_nxt_s = 32'h0000_0000;
    end
  end

  // Register file and acknowledge state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      value_r <= 32'h0000_0000;
      mask_r  <= 8'hFF;
      blank_r <= 1'b0;
      ack_r   <= 1'b0;
      dat_r   <= 32'h0000_0000;
    end else begin
      value_r <= value_nxt_s;
      mask_r  <= mask_nxt_s;
      blank_r <= blank_nxt_s;
      ack_r   <= ack_nxt_s;
      dat_r   <= dat_nxt_s;
    end
  end

  // Slot timer: cnt runs 0..DIV-1, and the digit index advances on each wrap.
  always_comb begin
    if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = {CW{1'b0}};
      idx_nxt_s = idx_r + 3'd1;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1'b1);
      idx_nxt_s = idx_r;
    end
  end

  // Scan position registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= 3'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
      idx_r <= idx_nxt_s;
    end
  end

`ifdef HEX_SCAN_BLINK_EN
  localparam int unsigned   BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_r;
  logic [BW-1:0] bcnt_nxt_s;
  logic          phase_r;
  logic          phase_nxt_s;
  logic [7:0]    blink_r;
  logic [7:0]    blink_nxt_s;

  // Blink phase timer and blink-mask write path.
  always_comb begin
    if (bcnt_r == BCNT_MAX) begin
      bcnt_nxt_s  = {BW{1'b0}};
      phase_nxt_s = ~phase_r;
    end else begin
      bcnt_nxt_s  = bcnt_r + BW'(1'b1);
      phase_nxt_s = phase_r;
    end
    if (wr_s && bus.adr_i) begin
      blink_nxt_s = ctrl_wr_s[23:16];
    end else begin
      blink_nxt_s = blink_r;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bcnt_r  <= {BW{1'b0}};
      phase_r <= 1'b0;
      blink_r <= 8'h00;
    end else begin
      bcnt_r  <= bcnt_nxt_s;
      phase_r <= phase_nxt_s;
      blink_r <= blink_nxt_s;
    end
  end

  assign blink_rd_s = blink_r;
  assign hide_s     = phase_nxt_s & blink_r[idx_nxt_s];
`else
  assign blink_rd_s = 8'h00;
  assign hide_s     = 1'b0;
`endif

  // Reserved CTRL bits (and BLINK_DIV in the plain build) are intentionally dropped.
  logic unused_ctrl_s;
  assign unused_ctrl_s = ^{ctrl_wr_s[31:9], BLINK_DIV[0]};

  // Output images are computed from the coming scan position so they align with cnt.
  always_comb begin
    dig_on_s     = mask_r[idx_nxt_s] & ~blank_r & ~hide_s;
    nibble_nxt_s = value_r[{idx_nxt_s, 2'b00} +: 4];
    if ((cnt_nxt_s == {CW{1'b0}}) || !dig_on_s) begin
      dig_n_nxt_s = 8'hFF;
    end else begin
      dig_n_nxt_s = ~(8'h01 << idx_nxt_s);
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      nibble_r <= 4'h0;
      dig_n_r  <= 8'hFF;
    end else begin
      nibble_r <= nibble_nxt_s;
      dig_n_r  <= dig_n_nxt_s;
    end
  end

  assign nibble_o  = nibble_r;
  assign dig_n_o   = dig_n_r;
  assign bus.ack_o = ack_r;
  assign bus.dat_o = dat_r;

endmodule

// File: tb/tb_hex_scan.sv
// Randomised scoreboard bench for hex_scan: a per-edge reference model queues expectations, a negedge monitor checks them.
module tb_hex_scan;
  localparam int DIV       = 4;
  localparam int BLINK_DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] nibble;
  logic [7:0] dig_n;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  hex_scan_if bus();

  hex_scan #(.DIV(DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .bus      (bus),
    .nibble_o (nibble),
    .dig_n_o  (dig_n)
  );

  typedef struct packed {
    logic        ack;
    logic        rd;
    logic [31:0] dat;
    logic [7:0]  dig;
    logic [3:0]  nib;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_value;
  logic [31:0] m_ctrl;
  logic        m_ack;
  int          m_k;

`ifdef HEX_SCAN_BLINK_EN
  localparam logic [31:0] CTRL_WMASK = 32'h00FF_01FF;
`else
  localparam logic [31:0] CTRL_WMASK = 32'h0000_01FF;
`endif

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Expected digit selects k edges after reset release, from the register image held before that edge.
  function automatic logic [7:0] exp_dig(input int k, input logic [31:0] ctrl);
    int cnt;
    int idx;
    bit on;
    cnt = k % DIV;
    idx = (k / DIV) % 8;
    on  = ctrl[idx] && !ctrl[8];
`ifdef HEX_SCAN_BLINK_EN
    if (((k / BLINK_DIV) % 2) == 1 && ctrl[16 + idx]) on = 1'b0;
`endif
    if (cnt == 0 || !on) return 8'hFF;
    return ~(8'h01 << idx);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated at every active edge, pushes what the DUT must show after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      e = '0;
      if (!rst_n) begin
        m_value = 32'h0;
        m_ctrl  = 32'h0000_00FF;
        m_ack   = 1'b0;
        m_k     = 0;
        e.dig   = 8'hFF;
        e.nib   = 4'h0;
      end else begin
        m_k++;
        e.dig = exp_dig(m_k, m_ctrl);
        e.nib = m_value[4*((m_k / DIV) % 8) +: 4];
        if (bus.cyc_i && bus.stb_i && !m_ack) begin
          m_ack = 1'b1;
          if (bus.we_i) begin
            if (bus.adr_i) m_ctrl = merge(m_ctrl, bus.dat_i, bus.sel_i) & CTRL_WMASK;
            else           m_value = merge(m_value, bus.dat_i, bus.sel_i);
          end else begin
            e.rd  = 1'b1;
            e.dat = bus.adr_i ? m_ctrl : m_value;
          end
        end else begin
          m_ack = 1'b0;
        end
        e.ack = m_ack;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack", 32'(bus.ack_o), 32'(e.ack));
        check("dig_n", 32'(dig_n), 32'(e.dig));
        check("nibble", 32'(nibble), 32'(e.nib));
        if (e.rd)        check("rdata", bus.dat_o, e.dat);
        else if (!e.ack) check("dat_idle", bus.dat_o, 32'h0);
      end
    end
  end

  task automatic xfer(input logic we, input logic adr, input logic [3:0] sel, input logic [31:0] dat);
    int n;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.sel_i = sel;
    bus.dat_i = dat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack_o && n < 6);
    check("ack_seen", 32'(bus.ack_o), 32'h1);
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus: directed scenarios, then randomised traffic, then a reset under a held strobe.
  initial begin
    logic        r_we;
    logic        r_adr;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = 1'b0;
    bus.sel_i = 4'h0;
    bus.dat_i = 32'h0;
    idle(3);
    rst_n = 1'b1;
    idle(40);
    xfer(1'b1, 1'b0, 4'hF, 32'h89AB_CDEF);
    xfer(1'b0, 1'b0, 4'hF, 32'h0);
    idle(34);
    xfer(1'b1, 1'b0, 4'b0010, 32'h0000_5500);
    xfer(1'b0, 1'b0, 4'hF, 32'h0);
    xfer(1'b1, 1'b1, 4'hF, 32'h0000_000F);
    idle(40);
    xfer(1'b0, 1'b1, 4'hF, 32'h0);
    xfer(1'b1, 1'b1, 4'hF, 32'h0000_0100);
    idle(36);
    xfer(1'b1, 1'b1, 4'hF, 32'h0001_00FF);
    xfer(1'b0, 1'b1, 4'hF, 32'h0);
    idle(70);
    for (int i = 0; i < 80; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_adr = 1'($urandom_range(0, 1));
      r_sel = 4'($urandom_range(0, 15));
      r_dat = $urandom;
      xfer(r_we, r_adr, r_sel, r_dat);
      idle($urandom_range(0, 5));
    end
    xfer(1'b1, 1'b1, 4'hF, 32'h00FF_00FF);
    xfer(1'b1, 1'b0, 4'hF, 32'h1234_5678);
    idle(6);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b0;
    bus.adr_i = 1'b0;
    idle(7);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(6);
    bus.adr_i = 1'b1;
    idle(4);
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    idle(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
